// File: rtl/qduc_pkg.sv
// rtl/qduc_pkg.sv - shared state type, width helpers and saturation for qduc_interp
//
// Contents:
//   qduc_state_e   run-control states (IDLE, RUN, DRAIN)
//   qduc_w()       internal CIC width W = ISZ + N*RW
//   qduc_sw()      shift field width SW = $clog2(W)
//   qduc_saturate  clamp a signed value to the range of an osz-bit signed word
package qduc_pkg;

   typedef enum logic [1:0] {
      QS_IDLE  = 2'd0,
      QS_RUN   = 2'd1,
      QS_DRAIN = 2'd2
   } qduc_state_e;

   function automatic int qduc_w(input int isz, input int n, input int rw);
      return isz + n * rw;
   endfunction

   function automatic int qduc_sw(input int isz, input int n, input int rw);
      return $clog2(isz + n * rw);
   endfunction

   // Values are carried at 64 bits, so W must not exceed 64 (ISZ=16, N=6, RW=8 is the limit).
   function automatic logic signed [63:0] qduc_saturate(input logic signed [63:0] v,
                                                        input int osz);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (osz - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/cic_interp_core.sv
// rtl/cic_interp_core.sv - one channel of the CIC interpolator: comb, zero-stuff, integrators, output
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   run_i        datapath advances this cycle (RUN or DRAIN)
//   clr_i        synchronous clear of every register (taken when heading to IDLE)
//   strobe_i     low-rate sample instant; x_i is pushed through the comb chain
//   x_i          signed ISZ-bit input sample (already zeroed by the top when not taken)
//   shift_i      arithmetic right shift applied to the last integrator
//   y_o          signed OSZ-bit output sample
//   sat_o        output was clamped (only with QDUC_SAT_EN, otherwise 0)
// Build option: QDUC_SAT_EN selects clamping instead of wrap-around narrowing.
module cic_interp_core
   import qduc_pkg::*;
#(
   parameter  int ISZ = 16,
   parameter  int OSZ = 14,
   parameter  int N   = 4,
   parameter  int RW  = 8,
   localparam int W   = qduc_w(ISZ, N, RW),
   localparam int SW  = qduc_sw(ISZ, N, RW)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           run_i,
   input  logic           clr_i,
   input  logic           strobe_i,
   input  logic [ISZ-1:0] x_i,
   input  logic [SW-1:0]  shift_i,
   output logic [OSZ-1:0] y_o,
   output logic           sat_o
);

   logic [W-1:0]   dly_q   [N];
   logic [W-1:0]   tap_d   [N];
   logic [W-1:0]   integ_q [N];
   logic [W-1:0]   comb_acc;
   logic [W-1:0]   comb_d;
   logic [W-1:0]   comb_q;
   logic           stb_q;
   logic [OSZ-1:0] y_d;
   logic [OSZ-1:0] y_q;
   logic           sat_d;
   logic           sat_q;

   // Comb chain: stage k subtracts its own previous input; all arithmetic wraps mod 2^W.
   always_comb begin
      comb_acc = {{(W - ISZ){x_i[ISZ-1]}}, x_i};
      for (int k = 0; k < N; k++) begin
         tap_d[k] = comb_acc;
         comb_acc = comb_acc - dly_q[k];
      end
      comb_d = comb_acc;
   end

`ifdef QDUC_SAT_EN
   logic signed [63:0] ext_w;
   logic signed [63:0] clamp_w;
   assign ext_w   = $signed(64'($signed(integ_q[N-1]))) >>> shift_i;
   assign clamp_w = qduc_saturate(ext_w, OSZ);
   assign y_d     = clamp_w[OSZ-1:0];
   assign sat_d   = (clamp_w != ext_w);
`else
   // Narrowing keeps the low OSZ bits of the shifted accumulator, so large values wrap.
   assign y_d     = OSZ'($signed(integ_q[N-1]) >>> shift_i);
   assign sat_d   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            dly_q[k]   <= '0;
            integ_q[k] <= '0;
         end
         comb_q <= '0;
         stb_q  <= 1'b0;
         y_q    <= '0;
         sat_q  <= 1'b0;
      end else if (clr_i) begin
         for (int k = 0; k < N; k++) begin
            dly_q[k]   <= '0;
            integ_q[k] <= '0;
         end
         comb_q <= '0;
         stb_q  <= 1'b0;
         y_q    <= '0;
         sat_q  <= 1'b0;
      end else if (run_i) begin
         if (strobe_i) begin
            for (int k = 0; k < N; k++) begin
               dly_q[k] <= tap_d[k];
            end
            comb_q <= comb_d;
         end
         stb_q <= strobe_i;
         // Zero-stuffing: the comb result enters the integrators only in the cycle after its strobe.
         integ_q[0] <= integ_q[0] + (stb_q ? comb_q : '0);
         for (int k = 1; k < N; k++) begin
            integ_q[k] <= integ_q[k] + integ_q[k-1];
         end
         y_q   <= y_d;
         sat_q <= sat_d;
      end
   end

   assign y_o   = y_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/qduc_interp.sv
// rtl/qduc_interp.sv - two-channel (I/Q) CIC interpolator with runtime ratio, handshake and drain
//
// Ports:
//   clk           sole clock, posedge
//   reset         asynchronous active-low reset
//   enable        run request
//   rate          ratio minus one (R = rate+1), latched on IDLE->RUN
//   shift         output arithmetic right shift, latched on IDLE->RUN
//   in_valid      input sample valid
//   in_ready      sample accepted this cycle when in_valid & in_ready
//   in_i, in_q    signed ISZ-bit I/Q input
//   out_valid     out_i/out_q carry a live sample
//   out_i, out_q  signed OSZ-bit I/Q output
//   underrun      sticky: a RUN strobe found in_valid low
//   underrun_clr  clears underrun (a coincident new underrun wins)
//   sat           either channel clamped its output this cycle
// Build option: QDUC_SAT_EN (clamp instead of wrap, drives sat).
module qduc_interp
   import qduc_pkg::*;
#(
   parameter  int ISZ = 16,
   parameter  int OSZ = 14,
   parameter  int N   = 4,
   parameter  int RW  = 8,
   localparam int SW  = qduc_sw(ISZ, N, RW)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic [RW-1:0]  rate,
   input  logic [SW-1:0]  shift,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [ISZ-1:0] in_i,
   input  logic [ISZ-1:0] in_q,
   output logic           out_valid,
   output logic [OSZ-1:0] out_i,
   output logic [OSZ-1:0] out_q,
   output logic           underrun,
   input  logic           underrun_clr,
   output logic           sat
);

   localparam int DCW = $clog2(N + 1);

   qduc_state_e    state_q;
   qduc_state_e    state_d;
   logic [RW-1:0]  cnt_q;
   logic [RW-1:0]  cnt_d;
   logic [RW-1:0]  rate_q;
   logic [SW-1:0]  shift_q;
   logic [DCW-1:0] dcnt_q;
   logic [DCW-1:0] dcnt_d;
   logic           underrun_q;
   logic           underrun_d;
   logic           ov_q;
   logic           ov_d;
   logic           strobe;
   logic           running;
   logic           take;
   logic           core_run;
   logic           core_clr;
   logic [ISZ-1:0] x_i_w;
   logic [ISZ-1:0] x_q_w;
   logic           sat_i_w;
   logic           sat_q_w;

   assign running  = (state_q == QS_RUN);
   assign strobe   = (state_q != QS_IDLE) && (cnt_q == rate_q);
   assign take     = strobe & running & in_valid;
   // Missing samples in RUN and every DRAIN strobe feed zeros into the comb chain.
   assign x_i_w    = take ? in_i : '0;
   assign x_q_w    = take ? in_q : '0;
   assign core_run = (state_q != QS_IDLE);
   // Clearing on the next state means the first IDLE cycle already shows a zero datapath.
   assign core_clr = (state_d == QS_IDLE);

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         QS_IDLE: begin
            if (enable) state_d = QS_RUN;
         end
         QS_RUN: begin
            if (!enable) begin
               state_d = QS_DRAIN;
               dcnt_d  = '0;
            end
         end
         QS_DRAIN: begin
            if (enable) begin
               state_d = QS_RUN;
            end else if (strobe) begin
               if (dcnt_q == DCW'(N - 1)) state_d = QS_IDLE;
               else                       dcnt_d  = dcnt_q + 1'b1;
            end
         end
         default: state_d = QS_IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = (state_q == QS_IDLE || strobe) ? '0 : cnt_q + 1'b1;
      underrun_d = (underrun_q & ~underrun_clr) | (strobe & running & ~in_valid);
      ov_d       = (state_q != QS_IDLE) && (state_d != QS_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= QS_IDLE;
         cnt_q      <= '0;
         rate_q     <= '0;
         shift_q    <= '0;
         dcnt_q     <= '0;
         underrun_q <= 1'b0;
         ov_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dcnt_q     <= dcnt_d;
         underrun_q <= underrun_d;
         ov_q       <= ov_d;
         if (state_q == QS_IDLE && enable) begin
            rate_q  <= rate;
            shift_q <= shift;
         end
      end
   end

   cic_interp_core #(.ISZ(ISZ), .OSZ(OSZ), .N(N), .RW(RW)) u_core_i (
      .clk      (clk),
      .reset    (reset),
      .run_i    (core_run),
      .clr_i    (core_clr),
      .strobe_i (strobe),
      .x_i      (x_i_w),
      .shift_i  (shift_q),
      .y_o      (out_i),
      .sat_o    (sat_i_w)
   );

   cic_interp_core #(.ISZ(ISZ), .OSZ(OSZ), .N(N), .RW(RW)) u_core_q (
      .clk      (clk),
      .reset    (reset),
      .run_i    (core_run),
      .clr_i    (core_clr),
      .strobe_i (strobe),
      .x_i      (x_q_w),
      .shift_i  (shift_q),
      .y_o      (out_q),
      .sat_o    (sat_q_w)
   );

   assign in_ready  = strobe & running;
   assign out_valid = ov_q;
   assign underrun  = underrun_q;
   assign sat       = sat_i_w | sat_q_w;

endmodule

// File: tb/tb_qduc_interp.sv
// tb/tb_qduc_interp.sv - directed self-checking bench for qduc_interp
module tb_qduc_interp;

   localparam int ISZ = 16;
   localparam int OSZ = 14;
   localparam int N   = 4;
   localparam int RW  = 8;
   localparam int SW  = 6;

`ifdef QDUC_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic           clk          = 1'b0;
   logic           reset        = 1'b0;
   logic           enable       = 1'b0;
   logic [RW-1:0]  rate         = '0;
   logic [SW-1:0]  shift        = '0;
   logic           in_valid     = 1'b0;
   logic [ISZ-1:0] in_i         = '0;
   logic [ISZ-1:0] in_q         = '0;
   logic           underrun_clr = 1'b0;
   logic           in_ready;
   logic           out_valid;
   logic [OSZ-1:0] out_i;
   logic [OSZ-1:0] out_q;
   logic           underrun;
   logic           sat;

   int tests = 0;
   int fails = 0;

   qduc_interp #(.ISZ(ISZ), .OSZ(OSZ), .N(N), .RW(RW)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .rate         (rate),
      .shift        (shift),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_i         (in_i),
      .in_q         (in_q),
      .out_valid    (out_valid),
      .out_i        (out_i),
      .out_q        (out_q),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .sat          (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic wait_ready();
      int i;
      i = 0;
      while (!in_ready && i < 64) begin
         tick();
         i++;
      end
      if (!in_ready) check("ready_timeout", 0, 1);
   endtask

   task automatic measure_period(output int n);
      wait_ready();
      tick();
      n = 1;
      while (!in_ready && n < 64) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (out_valid && i < 200) begin
         tick();
         i++;
      end
      if (out_valid) check("idle_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int mn;
      int any_ready;

      @(negedge clk);
      tick(2);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_i", $signed(out_i), 0);
      check("rst_underrun", underrun, 0);
      check("rst_sat", sat, 0);
      reset = 1'b1;
      tick();

      // R = 1: a strobe every cycle, unity DC gain.
      rate     = 8'd0;
      shift    = 6'd0;
      in_i     = 16'sd1000;
      in_q     = -16'sd1000;
      in_valid = 1'b1;
      enable   = 1'b1;
      tick();
      n = 0;
      repeat (8) begin
         if (in_ready) n++;
         tick();
      end
      check("r1_ready_count", n, 8);
      tick(10);
      check("r1_out_i", $signed(out_i), 1000);
      check("r1_out_q", $signed(out_q), -1000);
      check("r1_out_valid", out_valid, 1);
      enable = 1'b0;
      wait_idle();
      check("r1_idle_out_i", $signed(out_i), 0);

      // R = 4, shift 6: DC gain 4^3 = 64 cancelled by the shift.
      rate   = 8'd3;
      shift  = 6'd6;
      enable = 1'b1;
      tick(40);
      check("dc_out_i", $signed(out_i), 1000);
      check("dc_out_q", $signed(out_q), -1000);
      check("dc_out_valid", out_valid, 1);
      check("dc_sat", sat, 0);
      n = 0;
      repeat (16) begin
         if (in_ready) n++;
         tick();
      end
      check("dc_ready_count", n, 4);
      measure_period(n);
      check("dc_ready_period", n, 4);

      // Missing sample on a strobe.
      wait_ready();
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      check("underrun_set", underrun, 1);
      mn = 1000;
      repeat (30) begin
         if ($signed(out_i) < mn) mn = $signed(out_i);
         tick();
      end
      check("zero_inserted_dip", (mn < 1000), 1);
      tick(20);
      check("underrun_recover", $signed(out_i), 1000);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      check("underrun_clr", underrun, 0);
      wait_ready();
      in_valid     = 1'b0;
      underrun_clr = 1'b1;
      tick();
      in_valid     = 1'b1;
      underrun_clr = 1'b0;
      check("underrun_clr_coincident", underrun, 1);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      check("underrun_clr_again", underrun, 0);

      // Rate change while running is ignored.
      rate = 8'd7;
      tick(3);
      measure_period(n);
      check("rate_ignored_period", n, 4);

      // Drain: 4 zero strobes at R=4, no ready while draining, then cleared.
      tick(40);
      enable    = 1'b0;
      n         = 0;
      any_ready = 0;
      while (out_valid && n < 100) begin
         tick();
         n++;
         if (in_ready) any_ready = 1;
      end
      check("drain_len_ok", (n >= 14 && n <= 17), 1);
      check("drain_no_ready", any_ready, 0);
      check("drain_out_i", $signed(out_i), 0);
      check("drain_out_q", $signed(out_q), 0);
      check("drain_in_ready", in_ready, 0);

      // Re-enable via IDLE picks up rate 7: period 8, gain 8^3 = 512 -> 8000.
      enable = 1'b1;
      measure_period(n);
      check("rate_latched_period", n, 8);
      tick(60);
      check("r8_out_i", $signed(out_i), 8000);
      check("r8_out_q", $signed(out_q), -8000);
      shift = 6'd0;
      tick(5);
      check("shift_ignored", $signed(out_i), 8000);
      enable = 1'b0;
      wait_idle();

      // Saturation: 32767 * 64 = 2097088, low 14 bits are -64.
      rate   = 8'd3;
      shift  = 6'd0;
      in_i   = 16'sd32767;
      in_q   = 16'sd0;
      enable = 1'b1;
      tick(40);
      check("sat_out_i", $signed(out_i), SAT_EN ? 8191 : -64);
      check("sat_flag", sat, SAT_EN ? 1 : 0);
      check("sat_out_q", $signed(out_q), 0);

      // Asynchronous reset in the middle of RUN.
      reset = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_i", $signed(out_i), 0);
      check("arst_in_ready", in_ready, 0);
      enable = 1'b0;
      tick();
      check("arst_hold_out_valid", out_valid, 0);
      check("arst_hold_sat", sat, 0);
      reset = 1'b1;
      tick(2);
      check("arst_idle_ready", in_ready, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
